// File: rtl/modport_io_if.sv
// Configuration register port of the pad multiplexer, grouped as an interface.
// The SoC side is the master and the pad mux is the slave.
interface modport_io_if;
  logic        we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/modport_io.sv
// Chip-boundary pad multiplexer: per-pad GPIO/UART routing, pad configuration
// registers, registered pad inputs, boot-select latch and a divided slow clock.
module modport_io #(
  parameter int NPADS         = 48,
  parameter int SLOW_DIV_HALF = 4
) (
  input  logic                  ref_clk_i,
  input  logic                  rst_i,
  input  logic                  bootsel_i,
  input  logic                  stm_i,
  input  logic [NPADS-1:0]      io_in_i,
  output logic [NPADS-1:0]      io_out_o,
  output logic [NPADS-1:0]      io_oe_o,
  output logic [NPADS-1:0][5:0] pad_cfg_o,
  output logic                  slow_clk_o,
  input  logic                  uart0_tx_i,
  output logic                  uart0_rx_o,
  input  logic                  uart1_tx_i,
  output logic                  uart1_rx_o,
  output logic [NPADS-1:0]      gpio_in_o,
  output logic                  bootsel_o,
  modport_io_if.slave           cfg
);

  localparam int         CW      = (SLOW_DIV_HALF > 1) ? $clog2(SLOW_DIV_HALF) : 1;
  localparam logic [5:0] NPADS_A = 6'(NPADS);

  logic [9:0]       pad_q [NPADS];
  logic [9:0]       pad_d [NPADS];
  logic [NPADS-1:0] gpio_in_q, gpio_in_d;
  logic             bootsel_q, bootsel_d;
  logic             boot_done_q, boot_done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             slow_q, slow_d;

  // Pads 7..10 come up routed to the UARTs (7/10 receive, 8/9 transmit).
  function automatic logic [9:0] pad_rst_val(input int n);
    if ((n >= 7) && (n <= 10)) begin
      return 10'h001;
    end else begin
      return 10'h000;
    end
  endfunction

  // Next-state logic for registers, input sampling, boot latch and divider.
  always_comb begin
    for (int n = 0; n < NPADS; n++) begin
      pad_d[n] = (cfg.we && (cfg.addr == 6'(n))) ? cfg.wdata[9:0] : pad_q[n];
    end
    gpio_in_d   = io_in_i;
    boot_done_d = 1'b1;
    bootsel_d   = boot_done_q ? bootsel_q : bootsel_i;
    if (cnt_q == CW'(SLOW_DIV_HALF - 1)) begin
      cnt_d  = {CW{1'b0}};
      slow_d = ~slow_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      slow_d = slow_q;
    end
  end

  // State registers.
  always_ff @(posedge ref_clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NPADS; n++) begin
        pad_q[n] <= pad_rst_val(n);
      end
      gpio_in_q   <= {NPADS{1'b0}};
      bootsel_q   <= 1'b0;
      boot_done_q <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      slow_q      <= 1'b0;
    end else begin
      for (int n = 0; n < NPADS; n++) begin
        pad_q[n] <= pad_d[n];
      end
      gpio_in_q   <= gpio_in_d;
      bootsel_q   <= bootsel_d;
      boot_done_q <= boot_done_d;
      cnt_q       <= cnt_d;
      slow_q      <= slow_d;
    end
  end

  // Per-pad output mux; structural test mode tri-states every pad.
  always_comb begin
    io_out_o = {NPADS{1'b0}};
    io_oe_o  = {NPADS{1'b0}};
    for (int n = 0; n < NPADS; n++) begin
      pad_cfg_o[n] = pad_q[n][7:2];
      if (stm_i) begin
        io_out_o[n] = 1'b0;
        io_oe_o[n]  = 1'b0;
      end else begin
        case (pad_q[n][1:0])
          2'd0: begin
            io_out_o[n] = pad_q[n][8];
            io_oe_o[n]  = pad_q[n][9];
          end
          2'd1: begin
            if (n == 8) begin
              io_out_o[n] = uart0_tx_i;
              io_oe_o[n]  = 1'b1;
            end else if (n == 9) begin
              io_out_o[n] = uart1_tx_i;
              io_oe_o[n]  = 1'b1;
            end else begin
              io_out_o[n] = 1'b0;
              io_oe_o[n]  = 1'b0;
            end
          end
          default: begin
            io_out_o[n] = 1'b0;
            io_oe_o[n]  = 1'b0;
          end
        endcase
      end
    end
  end

  // Register read-back and UART receive routing (idle-high when unrouted).
  always_comb begin
    if (cfg.addr < NPADS_A) begin
      cfg.rdata = {21'h000000, gpio_in_q[cfg.addr], pad_q[cfg.addr]};
    end else if (cfg.addr == NPADS_A) begin
      cfg.rdata = {31'h00000000, bootsel_q};
    end else begin
      cfg.rdata = 32'h00000000;
    end
    uart0_rx_o = (pad_q[7][1:0] == 2'd1)  ? io_in_i[7]  : 1'b1;
    uart1_rx_o = (pad_q[10][1:0] == 2'd1) ? io_in_i[10] : 1'b1;
  end

  assign gpio_in_o  = gpio_in_q;
  assign bootsel_o  = bootsel_q;
  assign slow_clk_o = slow_q;

endmodule

// File: tb/tb_modport_io.sv
// Directed and randomized bench for modport_io, checked against a register-level
// model of the pad mux kept in the bench.
module tb_modport_io;
  localparam int NP   = 48;
  localparam int HALF = 4;

  logic             ref_clk_i = 1'b0;
  logic             rst_i, bootsel_i, stm_i, uart0_tx_i, uart1_tx_i;
  logic [NP-1:0]    io_in_i, io_out_o, io_oe_o, gpio_in_o;
  logic [NP-1:0][5:0] pad_cfg_o;
  logic             slow_clk_o, uart0_rx_o, uart1_rx_o, bootsel_o;

  modport_io_if cfg_if ();

  modport_io dut (
    .ref_clk_i (ref_clk_i),
    .rst_i     (rst_i),
    .bootsel_i (bootsel_i),
    .stm_i     (stm_i),
    .io_in_i   (io_in_i),
    .io_out_o  (io_out_o),
    .io_oe_o   (io_oe_o),
    .pad_cfg_o (pad_cfg_o),
    .slow_clk_o(slow_clk_o),
    .uart0_tx_i(uart0_tx_i),
    .uart0_rx_o(uart0_rx_o),
    .uart1_tx_i(uart1_tx_i),
    .uart1_rx_o(uart1_rx_o),
    .gpio_in_o (gpio_in_o),
    .bootsel_o (bootsel_o),
    .cfg       (cfg_if)
  );

  always #5 ref_clk_i = ~ref_clk_i;

  logic [9:0]    pad_m [NP];
  logic [NP-1:0] gin_m;
  logic          boot_m, boot_cap_m;
  int            cyc_m;
  int            checks = 0;
  int            errors = 0;

  task automatic model_reset();
    for (int n = 0; n < NP; n++) pad_m[n] = (n >= 7 && n <= 10) ? 10'h001 : 10'h000;
    gin_m      = '0;
    boot_m     = 1'b0;
    boot_cap_m = 1'b0;
    cyc_m      = 0;
  endtask

  task automatic model_edge();
    if (!rst_i) begin
      if (cfg_if.we && cfg_if.addr < 6'd48) pad_m[cfg_if.addr] = cfg_if.wdata[9:0];
      gin_m = io_in_i;
      if (!boot_cap_m) begin
        boot_m     = bootsel_i;
        boot_cap_m = 1'b1;
      end
      cyc_m++;
    end
  endtask

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NP-1:0]      e_out, e_oe;
    logic [NP-1:0][5:0] e_cfg;
    logic [31:0]        e_rd;
    logic               e_u0, e_u1, e_slow;
    for (int n = 0; n < NP; n++) begin
      e_cfg[n] = pad_m[n][7:2];
      e_out[n] = 1'b0;
      e_oe[n]  = 1'b0;
      if (!stm_i) begin
        if (pad_m[n][1:0] == 2'd0) begin
          e_out[n] = pad_m[n][8];
          e_oe[n]  = pad_m[n][9];
        end else if (pad_m[n][1:0] == 2'd1 && n == 8) begin
          e_out[n] = uart0_tx_i;
          e_oe[n]  = 1'b1;
        end else if (pad_m[n][1:0] == 2'd1 && n == 9) begin
          e_out[n] = uart1_tx_i;
          e_oe[n]  = 1'b1;
        end
      end
    end
    e_u0   = (pad_m[7][1:0] == 2'd1) ? io_in_i[7] : 1'b1;
    e_u1   = (pad_m[10][1:0] == 2'd1) ? io_in_i[10] : 1'b1;
    e_slow = ((cyc_m / HALF) % 2) == 1;
    if (cfg_if.addr < 6'd48)       e_rd = {21'd0, gin_m[cfg_if.addr], pad_m[cfg_if.addr]};
    else if (cfg_if.addr == 6'd48) e_rd = {31'd0, boot_m};
    else                           e_rd = 32'd0;
    chk("io_out", io_out_o, e_out);
    chk("io_oe", io_oe_o, e_oe);
    chk("pad_cfg", pad_cfg_o, e_cfg);
    chk("uart0_rx", uart0_rx_o, e_u0);
    chk("uart1_rx", uart1_rx_o, e_u1);
    chk("gpio_in", gpio_in_o, gin_m);
    chk("bootsel", bootsel_o, boot_m);
    chk("slow_clk", slow_clk_o, e_slow);
    chk("rdata", cfg_if.rdata, e_rd);
  endtask

  task automatic tick();
    @(posedge ref_clk_i);
    model_edge();
    #2;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    cfg_if.we    = 1'b1;
    cfg_if.addr  = a;
    cfg_if.wdata = d;
    #1 check_all();
    tick();
    cfg_if.we = 1'b0;
  endtask

  task automatic randomize_inputs();
    logic [63:0] r;
    r            = {$urandom(), $urandom()};
    io_in_i      = r[NP-1:0];
    stm_i        = ($urandom_range(0, 7) == 0);
    uart0_tx_i   = 1'($urandom_range(0, 1));
    uart1_tx_i   = 1'($urandom_range(0, 1));
    bootsel_i    = 1'($urandom_range(0, 1));
    cfg_if.we    = 1'($urandom_range(0, 1));
    cfg_if.addr  = 6'($urandom_range(0, 63));
    cfg_if.wdata = $urandom();
  endtask

  initial begin
    rst_i = 1'b1; stm_i = 1'b0; uart0_tx_i = 1'b0; uart1_tx_i = 1'b1; bootsel_i = 1'b1;
    cfg_if.we = 1'b0; cfg_if.addr = 6'd0; cfg_if.wdata = 32'd0;
    io_in_i = 48'h0000_0000_0400;
    model_reset();
    #1 check_all();
    chk("rst_oe_const", io_oe_o, 48'h0000_0000_0300);
    chk("rst_out8", io_out_o[8], 1'b0);
    chk("rst_out9", io_out_o[9], 1'b1);
    io_in_i = 48'h0000_0000_0080;
    #1 check_all();

    // Boot select held high across reset release, then dropped.
    @(negedge ref_clk_i) rst_i = 1'b0;
    #1 check_all();
    tick();
    bootsel_i = 1'b0;
    #1 check_all();
    tick();
    #1 check_all();
    chk("bootsel_held", bootsel_o, 1'b1);

    wr(6'd8, 32'h0000_0300);
    uart0_tx_i = 1'b0;
    #1 check_all();
    chk("pad8_gpio", io_out_o[8], 1'b1);
    wr(6'd7, 32'h0000_0000);
    io_in_i[7] = 1'b0;
    #1 check_all();
    chk("uart0_idle", uart0_rx_o, 1'b1);

    wr(6'd20, 32'h0000_00FC);
    io_in_i[20]  = 1'b1;
    cfg_if.addr  = 6'd20;
    tick();
    #1 check_all();
    chk("pad20_cfg", pad_cfg_o[20], 6'h3F);
    chk("pad20_rd", cfg_if.rdata, 32'h0000_04FC);
    cfg_if.addr = 6'd48;
    #1 check_all();
    wr(6'd55, 32'hFFFF_FFFF);
    cfg_if.addr = 6'd55;
    #1 check_all();

    wr(6'd30, 32'h0000_0300);
    stm_i = 1'b1;
    #1 check_all();
    chk("stm_oe", io_oe_o, 48'h0);
    stm_i = 1'b0;
    #1 check_all();
    chk("stm_restore", io_oe_o[30], 1'b1);

    // Slow-clock phase from a fresh reset.
    rst_i = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge ref_clk_i) rst_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      #1 check_all();
      chk("slow_phase", slow_clk_o, ((k % 8) >= 4) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      #1 check_all();
      tick();
      if (i == 201) begin
        rst_i = 1'b1;
        model_reset();
        #1 check_all();
        chk("midrst_slow", slow_clk_o, 1'b0);
        @(negedge ref_clk_i) rst_i = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
